// File: rtl/sa_bitstream_if.sv
// Handshake and status bundle between an SA bitstream source and the decoder.
// The source drives the stream controls; the decoder drives counts and the result.
interface sa_bitstream_dec_if #(
    parameter int N = 7
);
    logic         start;
    logic         bit_valid;
    logic         bit_in;
    logic         term;
    logic         busy;
    logic [N:0]   bit_cnt;
    logic [N:0]   ones_cnt;
    logic [N-1:0] k_out;
    logic         k_valid;
    logic         early;
    logic         sat;

    modport master (
        output start, bit_valid, bit_in, term,
        input  busy, bit_cnt, ones_cnt, k_out, k_valid, early, sat
    );

    modport slave (
        input  start, bit_valid, bit_in, term,
        output busy, bit_cnt, ones_cnt, k_out, k_valid, early, sat
    );
endinterface

// File: rtl/sa_bitstream_dec.sv
// Streaming-accurate bitstream decoder: counts ones over an L = 2^N bit stream and
// recovers k, scaling the last power-of-two prefix count when the stream ends early.
module sa_bitstream_dec #(
    parameter int N = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    sa_bitstream_dec_if.slave   bus
);
    localparam int CW = N + 1;
    localparam int JW = $clog2(N + 1);
    localparam logic [CW-1:0] LEN = CW'(2 ** N);
    localparam logic [JW-1:0] NJ  = JW'(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  bitCnt_q, bitCnt_d;
    logic [CW-1:0]  onesCnt_q, onesCnt_d;
    logic [CW-1:0]  snap_q, snap_d;
    logic [JW-1:0]  jsnap_q, jsnap_d;
    logic [N-1:0]   kOut_q, kOut_d;
    logic           kValid_q, kValid_d;
    logic           early_q, early_d;
    logic           sat_q, sat_d;

    logic [CW-1:0]  cntInc;
    logic [CW-1:0]  est;
    logic           isPow;
    logic           doClear;
    logic [JW-1:0]  jInc;

    // Is the count after accepting one more bit a power of two, and which one?
    always_comb begin
        cntInc = bitCnt_q + CW'(1);
        isPow  = 1'b0;
        jInc   = '0;
        for (int j = 0; j <= N; j++) begin
            if (cntInc == (CW'(1) << j)) begin
                isPow = 1'b1;
                jInc  = JW'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        onesCnt_d = onesCnt_q;
        snap_d    = snap_q;
        jsnap_d   = jsnap_q;
        kOut_d    = kOut_q;
        kValid_d  = 1'b0;
        early_d   = 1'b0;
        sat_d     = 1'b0;
        est       = '0;
        doClear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    doClear = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.start) begin
                    doClear = 1'b1;
                end else begin
                    if (bus.bit_valid) begin
                        bitCnt_d  = cntInc;
                        onesCnt_d = onesCnt_q + CW'(bus.bit_in);
                        if (isPow) begin
                            snap_d  = onesCnt_d;
                            jsnap_d = jInc;
                        end
                    end
                    // A bit arriving together with term is counted before decoding.
                    if (bus.term || bitCnt_d == LEN) begin
                        state_d = DONE;
                        if (bitCnt_d == LEN) begin
                            est = onesCnt_d;
                        end else begin
                            est = snap_d << (NJ - jsnap_d);
                        end
                        kValid_d = 1'b1;
                        early_d  = (bitCnt_d != LEN);
                        sat_d    = est[N];
                        kOut_d   = est[N] ? '1 : est[N-1:0];
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    doClear = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (doClear) begin
            bitCnt_d  = '0;
            onesCnt_d = '0;
            snap_d    = '0;
            jsnap_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            onesCnt_q <= '0;
            snap_q    <= '0;
            jsnap_q   <= '0;
            kOut_q    <= '0;
            kValid_q  <= 1'b0;
            early_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            onesCnt_q <= onesCnt_d;
            snap_q    <= snap_d;
            jsnap_q   <= jsnap_d;
            kOut_q    <= kOut_d;
            kValid_q  <= kValid_d;
            early_q   <= early_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.bit_cnt  = bitCnt_q;
    assign bus.ones_cnt = onesCnt_q;
    assign bus.k_out    = kOut_q;
    assign bus.k_valid  = kValid_q;
    assign bus.early    = early_q;
    assign bus.sat      = sat_q;
endmodule

// File: tb/tb_sa_bitstream_dec.sv
// Bench for sa_bitstream_dec: table of directed streams, hand-written corner sequences,
// and randomized streams scored against a prefix-count reference model.
module tb_sa_bitstream_dec;
    localparam int N = 7;
    localparam int L = 1 << N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_bitstream_dec_if #(.N(N)) bus ();
    sa_bitstream_dec #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        int k; int nBits; int termMode; int gapPct; int pattern;
        int eK; int eEarly; int eSat; int eCnt; int eOnes;
    } vec_t;

    int total = 0;
    int bad = 0;
    bit sentBits[$];
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ones in the first n bits of an SA stream whose accumulator starts at L/2.
    function automatic int saOnes(input int k, input int n);
        return (n * k + L / 2) / L;
    endfunction

    function automatic bit patBit(input int pattern, input int k, input int i);
        if (pattern == 0) return bit'(saOnes(k, i) - saOnes(k, i - 1));
        if (pattern == 1) return 1'b1;
        return bit'($urandom_range(1));
    endfunction

    task automatic idleInputs();
        bus.start = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.term = 1'b0;
    endtask

    task automatic startStream();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        sentBits.delete();
    endtask

    task automatic sendBits(input int k, input int n, input bit termLast, input int gapPct,
                            input int pattern);
        for (int i = 1; i <= n; i++) begin
            while (int'($urandom_range(99)) < gapPct) begin
                bus.bit_valid = 1'b0;
                bus.bit_in = 1'($urandom_range(1));
                step();
            end
            bus.bit_valid = 1'b1;
            bus.bit_in = patBit(pattern, k, i);
            bus.term = termLast && (i == n);
            sentBits.push_back(bus.bit_in);
            step();
        end
        idleInputs();
    endtask

    // termMode: 0 none (full stream), 1 term with the last bit, 2 term in its own cycle.
    task automatic applyStimulus(input int k, input int n, input int termMode, input int gapPct,
                                 input int pattern);
        startStream();
        sendBits(k, n, termMode == 1, gapPct, pattern);
        if (termMode == 2) begin
            bus.term = 1'b1;
            step();
            bus.term = 1'b0;
        end
    endtask

    // Reference: full stream decodes the ones count; an early stream scales the ones
    // in its longest power-of-two prefix up to L.
    task automatic computeExpected(output int eK, output int eEarly, output int eSat,
                                   output int eCnt, output int eOnes);
        int n, est, p, po;
        n = sentBits.size();
        eOnes = 0;
        foreach (sentBits[i]) eOnes += int'(sentBits[i]);
        if (n == L) est = eOnes;
        else if (n == 0) est = 0;
        else begin
            p = 1;
            while (p * 2 <= n) p = p * 2;
            po = 0;
            for (int i = 0; i < p; i++) po += int'(sentBits[i]);
            est = po * (L / p);
        end
        eSat = (est >= L) ? 1 : 0;
        eK = eSat ? L - 1 : est;
        eEarly = (n < L) ? 1 : 0;
        eCnt = n;
    endtask

    // Expects k_valid the cycle after termination, then one DONE cycle that drops bits.
    task automatic checkOutput(input string name, input int eK, input int eEarly, input int eSat,
                               input int eCnt, input int eOnes);
        int waited = 0;
        while (!bus.k_valid && waited < 4) begin
            step();
            waited++;
        end
        check({name, ".latency"}, waited, 0);
        check({name, ".kValid"}, int'(bus.k_valid), 1);
        check({name, ".kOut"}, int'(bus.k_out), eK);
        check({name, ".early"}, int'(bus.early), eEarly);
        check({name, ".sat"}, int'(bus.sat), eSat);
        check({name, ".bitCnt"}, int'(bus.bit_cnt), eCnt);
        check({name, ".onesCnt"}, int'(bus.ones_cnt), eOnes);
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        step();
        idleInputs();
        check({name, ".pulseEnd"}, int'(bus.k_valid), 0);
        check({name, ".idle"}, int'(bus.busy), 0);
        check({name, ".cntHeld"}, int'(bus.bit_cnt), eCnt);
        check({name, ".kHeld"}, int'(bus.k_out), eK);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int eK, eEarly, eSat, eCnt, eOnes, k, n, tm, pat;

        vecs[0] = '{64, 128, 0, 0, 0, 64, 0, 0, 128, 64};
        vecs[1] = '{127, 128, 0, 30, 0, 127, 0, 0, 128, 127};
        vecs[2] = '{0, 128, 0, 30, 0, 0, 0, 0, 128, 0};
        vecs[3] = '{0, 128, 0, 0, 1, 127, 0, 1, 128, 128};
        vecs[4] = '{96, 64, 1, 0, 0, 96, 1, 0, 64, 48};
        vecs[5] = '{96, 100, 1, 10, 0, 96, 1, 0, 100, 75};
        vecs[6] = '{127, 64, 1, 0, 0, 127, 1, 1, 64, 64};
        vecs[7] = '{0, 0, 2, 0, 0, 0, 1, 0, 0, 0};
        vecs[8] = '{32, 128, 0, 0, 0, 32, 0, 0, 128, 32};
        vecs[9] = '{96, 64, 2, 0, 0, 96, 1, 0, 64, 48};

        idleInputs();
        #12;
        check("reset.busy", int'(bus.busy), 0);
        check("reset.kOut", int'(bus.k_out), 0);
        check("reset.kValid", int'(bus.k_valid), 0);
        check("reset.bitCnt", int'(bus.bit_cnt), 0);
        check("reset.onesCnt", int'(bus.ones_cnt), 0);
        check("reset.earlySat", int'({bus.early, bus.sat}), 0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].k, vecs[i].nBits, vecs[i].termMode, vecs[i].gapPct,
                          vecs[i].pattern);
            checkOutput($sformatf("vec%0d", i), vecs[i].eK, vecs[i].eEarly, vecs[i].eSat,
                        vecs[i].eCnt, vecs[i].eOnes);
        end

        // term in IDLE must leave everything alone; last result was 96
        bus.term = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idleTerm.busy", int'(bus.busy), 0);
            check("idleTerm.kValid", int'(bus.k_valid), 0);
        end
        bus.term = 1'b0;
        check("idleTerm.kOut", int'(bus.k_out), 96);

        // start and term together: start wins, both from IDLE and inside RUN
        bus.start = 1'b1; bus.term = 1'b1;
        step();
        check("startTerm.enter", int'(bus.busy), 1);
        step();
        check("startTerm.run", int'(bus.busy), 1);
        check("startTerm.noValid", int'(bus.k_valid), 0);
        idleInputs();
        step();
        check("startTerm.stillRun", int'(bus.busy), 1);
        check("startTerm.noValid2", int'(bus.k_valid), 0);
        sentBits.delete();
        bus.term = 1'b1;
        step();
        bus.term = 1'b0;
        checkOutput("termOnly", 0, 1, 0, 0, 0);

        // start during DONE restarts immediately and drops the DONE-cycle bit
        applyStimulus(64, 128, 0, 0, 0);
        check("doneStart.kValid", int'(bus.k_valid), 1);
        bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
        step();
        idleInputs();
        check("doneStart.busy", int'(bus.busy), 1);
        check("doneStart.bitCnt", int'(bus.bit_cnt), 0);
        check("doneStart.onesCnt", int'(bus.ones_cnt), 0);
        sentBits.delete();
        sendBits(16, 128, 1'b0, 0, 0);
        checkOutput("doneStart", 16, 0, 0, 128, 16);

        // abort at bit 50, then a full k=32 stream
        startStream();
        sendBits(32, 50, 1'b0, 0, 0);
        bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
        step();
        idleInputs();
        check("abort.bitCnt", int'(bus.bit_cnt), 0);
        check("abort.onesCnt", int'(bus.ones_cnt), 0);
        check("abort.busy", int'(bus.busy), 1);
        check("abort.kValid", int'(bus.k_valid), 0);
        sentBits.delete();
        sendBits(32, 128, 1'b0, 20, 0);
        checkOutput("afterAbort", 32, 0, 0, 128, 32);

        // asynchronous reset between clock edges mid-stream
        startStream();
        sendBits(32, 40, 1'b0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("asyncRst.busy", int'(bus.busy), 0);
        check("asyncRst.kOut", int'(bus.k_out), 0);
        check("asyncRst.kValid", int'(bus.k_valid), 0);
        check("asyncRst.bitCnt", int'(bus.bit_cnt), 0);
        #2 rst_n = 1'b1;
        step();
        check("asyncRst.idle", int'(bus.busy), 0);
        check("asyncRst.noValid", int'(bus.k_valid), 0);

        // randomized streams against the reference model
        for (int it = 0; it < 40; it++) begin
            k = int'($urandom_range(L - 1));
            n = int'($urandom_range(L));
            pat = ($urandom_range(2) == 0) ? 2 : 0;
            if (n == L) tm = int'($urandom_range(1));
            else if (n == 0) tm = 2;
            else tm = 1 + int'($urandom_range(1));
            applyStimulus(k, n, tm, int'($urandom_range(30)), pat);
            computeExpected(eK, eEarly, eSat, eCnt, eOnes);
            checkOutput($sformatf("rand%0d", it), eK, eEarly, eSat, eCnt, eOnes);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sa_bitstream_dec.md
Name: sa_bitstream_dec

Overview:
- Receiving end of the streaming-accurate (SA) stochastic link. Accepts a serial SA bitstream, one bit per valid cycle, and recovers the encoded value k.
- Supports early termination: a partial stream is decoded by scaling the ones-count captured at the last power-of-two length.
- Sits in the decompressor path, directly downstream of the SA bitstream generator or its channel.

Parameters:
- N, 7, value width; stream length L = 2^N.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a new stream; clears counters, enters RUN.
- bit_valid  in  1  bit_in is meaningful this cycle.
- bit_in  in  1  stochastic stream bit.
- term  in  1  early-termination request.
- busy  out  1  high in RUN.
- bit_cnt  out  N+1  bits accepted in the current stream, 0..L.
- ones_cnt  out  N+1  ones accepted in the current stream, 0..L.
- k_out  out  N  decoded value; held until the next k_valid.
- k_valid  out  1  one-cycle pulse when k_out updates.
- early  out  1  qualifies k_valid: the stream was terminated before L bits.
- sat  out  1  qualifies k_valid: the estimate exceeded 2^N-1 and was clamped.

Behaviour:
- Reset (async): state IDLE. bit_cnt, ones_cnt and the snapshot register (snap) = 0. k_out = 0. k_valid, early, sat, busy = 0.
- States:
  - IDLE: bits ignored. start -> RUN.
  - RUN: counting. Exits to DONE when bit_cnt reaches L or term is seen.
  - DONE: single cycle; k_valid = 1. Then -> IDLE, or -> RUN if start is high in that cycle.
- In RUN, each cycle with bit_valid=1: bit_cnt += 1, ones_cnt += bit_in. Counts are N+1 bits and never wrap, because acceptance stops at L.
- Snapshot: when the post-increment bit_cnt equals 2^j (j = 0..N), snap <= post-increment ones_cnt and jsnap <= j. snap is cleared on start.
- Exit to DONE:
  - On the cycle the L-th bit is accepted.
  - On term=1 in RUN. A same-cycle valid bit is counted first.
- Bits presented in the DONE cycle are dropped.
- Decode in DONE, registered, so k_valid is asserted the cycle after the terminating bit or term:
  - full stream (bit_cnt = L): est = ones_cnt.
  - early stream: est = snap << (N - jsnap), computed N+1 bits wide.
  - early, bit_cnt = 0: est = 0.
  - est >= 2^N: k_out = 2^N-1, sat = 1; otherwise k_out = est[N-1:0], sat = 0.
  - early = 1 iff bit_cnt < L.
- Valid SA streams (accumulator initialised to L/2) always decode exactly at L. Power-of-two prefixes give k rounded to the resolution L/2^j.
- k_valid, early and sat are registered pulses, high in the DONE cycle only.
- start in RUN: abort the current stream, clear the counters, stay in RUN; no k_valid. start in IDLE or DONE: enter RUN with the counters cleared.
- start and term in the same cycle: start wins; term is ignored.
- term in IDLE: ignored.
- rst_n low mid-stream: immediate return to the reset values; no k_valid.
- busy = 1 exactly in RUN.
- bit_cnt and ones_cnt hold their final values through DONE and IDLE until the next start.

Test Plan:
- Full stream: start, then 128 SA-encoded bits for k=64 with bit_valid continuous -> ones_cnt=64; k_out=64, k_valid pulse the cycle after bit 128; early=0, sat=0.
- Gapped stream: k=127 over 128 bits with bit_valid deasserted at random -> k_out=127, sat=0, bit_cnt=128. Then k=0 -> k_out=0.
- Non-SA input: 128 ones -> ones_cnt=128; k_out=127, sat=1, early=0.
- Early termination at a power of two: k=96 stream, term with the 64th bit -> snap=48, k_out=96, early=1.
  - Same stream, term after 100 bits -> k_out=96 (from the snapshot at 64), bit_cnt=100.
  - k=127, term at 64 -> k_out=127, sat=1.
- Boundary: term immediately after start with no bits -> k_out=0, early=1, k_valid one cycle later.
  - start and term in the same cycle -> stays in RUN, no k_valid.
  - term in IDLE -> no effect.
- Abort and reset: start at bit 50 -> counters clear, no k_valid; a following full k=32 stream decodes 32. rst_n pulsed low mid-stream (asynchronous, between clock edges) -> busy=0, k_out=0 immediately, no k_valid.
